// File: rtl/lcd_scanout.sv
// Purpose: scans a finished framebuffer out as a pixel stream with sof/eol/eof markers.
// Latency: render_complete at edge N -> first read in cycle N+1 -> first beat valid in cycle N+2.
// Backpressure: out_ready low holds the beat; a 2-entry FIFO plus read credit stops reads when full.
module lcd_scanout #(
    parameter int WIDTH  = 160,
    parameter int HEIGHT = 144,
    parameter int PIX_W  = 2,
    parameter int ADDR_W = 15
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              render_complete,
    output logic              pix_rd_en,
    output logic [ADDR_W-1:0] pix_addr,
    input  logic [PIX_W-1:0]  pix_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [PIX_W-1:0]  out_pixel,
    output logic              out_sof,
    output logic              out_eol,
    output logic              out_eof,
    output logic              busy,
    output logic              frame_done,
    output logic [7:0]        dropped
);

    localparam int XW = (WIDTH  > 1) ? $clog2(WIDTH)  : 1;
    localparam int YW = (HEIGHT > 1) ? $clog2(HEIGHT) : 1;
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(WIDTH * HEIGHT - 1);
    localparam logic [XW-1:0]     X_LAST    = XW'(WIDTH - 1);
    localparam logic [YW-1:0]     Y_LAST    = YW'(HEIGHT - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        DRAIN = 2'd2
    } state_t;

    typedef struct packed {
        logic [PIX_W-1:0] pix;
        logic             sof;
        logic             eol;
        logic             eof;
    } beat_t;

    state_t state;
    state_t state_nxt;

    logic [ADDR_W-1:0] addr;
    logic [XW-1:0]     x_cnt;
    logic [YW-1:0]     y_cnt;

    // one read may be in flight; its markers travel alongside until the data returns
    logic rd_pend;
    logic pend_sof;
    logic pend_eol;
    logic pend_eof;

    // two-entry FIFO, entry 0 is the head
    beat_t      fifo_q0;
    beat_t      fifo_q1;
    logic [1:0] fifo_cnt;

    beat_t      in_beat;
    beat_t      head;
    logic       pop;
    logic       last_xfer;
    logic [2:0] occ_after;
    logic       room;
    logic       start;

    // markers for the address being read right now
    logic rd_sof;
    logic rd_eol;
    logic rd_eof;

    // Datapath view: returning read data bypasses an empty FIFO so the first beat is not delayed.
    always_comb begin
        in_beat     = '0;
        in_beat.pix = pix_data;
        in_beat.sof = pend_sof;
        in_beat.eol = pend_eol;
        in_beat.eof = pend_eof;
        head        = (fifo_cnt != 2'd0) ? fifo_q0 : in_beat;
        out_valid   = (fifo_cnt != 2'd0) || rd_pend;
        pop         = out_valid && out_ready;
        last_xfer   = pop && head.eof;
        // storage still committed after this cycle's pop; a new read needs a free slot
        occ_after   = {1'b0, fifo_cnt} + {2'b00, rd_pend} - {2'b00, pop};
        room        = (occ_after < 3'd2);
        start       = (state == IDLE) && render_complete;
        rd_sof      = (x_cnt == '0) && (y_cnt == '0);
        rd_eol      = (x_cnt == X_LAST);
        rd_eof      = (x_cnt == X_LAST) && (y_cnt == Y_LAST);
        out_pixel   = out_valid ? head.pix : '0;
        out_sof     = out_valid && head.sof;
        out_eol     = out_valid && head.eol;
        out_eof     = out_valid && head.eof;
        pix_addr    = addr;
    end

    // State register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic plus the read strobe and busy flag.
    always_comb begin
        state_nxt = state;
        pix_rd_en = 1'b0;
        busy      = 1'b0;
        case (state)
            IDLE: begin
                if (render_complete) begin
                    state_nxt = FETCH;
                end
            end
            FETCH: begin
                busy      = 1'b1;
                pix_rd_en = room;
                if (room && (addr == LAST_ADDR)) begin
                    state_nxt = DRAIN;
                end
            end
            DRAIN: begin
                busy = 1'b1;
                if (last_xfer) begin
                    state_nxt = IDLE;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // Incremental raster walk: address and x/y advance together on each issued read.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            addr  <= '0;
            x_cnt <= '0;
            y_cnt <= '0;
        end else if (start) begin
            addr  <= '0;
            x_cnt <= '0;
            y_cnt <= '0;
        end else if (pix_rd_en) begin
            // the final address is held so the read port never points past the frame
            if (addr != LAST_ADDR) begin
                addr <= addr + ADDR_W'(1);
            end
            if (x_cnt == X_LAST) begin
                x_cnt <= '0;
                if (y_cnt != Y_LAST) begin
                    y_cnt <= y_cnt + YW'(1);
                end
            end else begin
                x_cnt <= x_cnt + XW'(1);
            end
        end
    end

    // Track the outstanding read and the markers that belong to it.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rd_pend  <= 1'b0;
            pend_sof <= 1'b0;
            pend_eol <= 1'b0;
            pend_eof <= 1'b0;
        end else begin
            rd_pend <= pix_rd_en;
            if (pix_rd_en) begin
                pend_sof <= rd_sof;
                pend_eol <= rd_eol;
                pend_eof <= rd_eof;
            end
        end
    end

    // FIFO update: returning data is written unless it was consumed directly through the bypass.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            fifo_q0  <= '0;
            fifo_q1  <= '0;
            fifo_cnt <= 2'd0;
        end else begin
            fifo_cnt <= fifo_cnt + {1'b0, rd_pend} - {1'b0, pop};
            case (fifo_cnt)
                2'd0: begin
                    if (rd_pend && !pop) begin
                        fifo_q0 <= in_beat;
                    end
                end
                2'd1: begin
                    if (rd_pend && pop) begin
                        fifo_q0 <= in_beat;
                    end else if (rd_pend) begin
                        fifo_q1 <= in_beat;
                    end
                end
                default: begin
                    // full FIFO implies no read in flight, so only a pop can happen
                    if (pop) begin
                        fifo_q0 <= fifo_q1;
                    end
                end
            endcase
        end
    end

    // Frame completion pulse and saturating count of ignored render requests.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            frame_done <= 1'b0;
            dropped    <= 8'd0;
        end else begin
            frame_done <= last_xfer;
            if (render_complete && (state != IDLE) && (dropped != 8'hFF)) begin
                dropped <= dropped + 8'd1;
            end
        end
    end

endmodule

// File: tb/tb_lcd_scanout.sv
module tb_lcd_scanout;

    localparam int W  = 160;
    localparam int H  = 144;
    localparam int N  = W * H;
    localparam int WS = 4;
    localparam int HS = 2;
    localparam int NS = WS * HS;

    typedef logic [4:0] beat_t;

    logic clk;
    logic reset;

    // full-size instance
    logic        rc;
    logic        rd_en;
    logic [14:0] addr;
    logic [1:0]  pdata;
    logic        ov;
    logic        ordy;
    logic [1:0]  opix;
    logic        sof, eol, eof;
    logic        busy;
    logic        fdone;
    logic [7:0]  dropped;

    // small instance
    logic        rc_s;
    logic        rd_en_s;
    logic [2:0]  addr_s;
    logic [1:0]  pdata_s;
    logic        ov_s;
    logic        ordy_s;
    logic [1:0]  opix_s;
    logic        sof_s, eol_s, eof_s;
    logic        busy_s;
    logic        fdone_s;
    logic [7:0]  dropped_s;

    logic [1:0] fb   [N];
    logic [1:0] fb_s [NS];

    beat_t exp_q[$];
    beat_t exp_qs[$];

    int n_cmp = 0;
    int n_err = 0;
    int beats = 0;
    int frames_mon = 0;
    int sof_n = 0;
    int eol_n = 0;
    int eof_n = 0;
    int fd_n = 0;
    int beats_s = 0;
    int frames_s = 0;
    int exp_drop = 0;

    lcd_scanout u_dut (
        .clk(clk), .reset(reset), .render_complete(rc),
        .pix_rd_en(rd_en), .pix_addr(addr), .pix_data(pdata),
        .out_valid(ov), .out_ready(ordy), .out_pixel(opix),
        .out_sof(sof), .out_eol(eol), .out_eof(eof),
        .busy(busy), .frame_done(fdone), .dropped(dropped)
    );

    lcd_scanout #(.WIDTH(WS), .HEIGHT(HS), .PIX_W(2), .ADDR_W(3)) u_small (
        .clk(clk), .reset(reset), .render_complete(rc_s),
        .pix_rd_en(rd_en_s), .pix_addr(addr_s), .pix_data(pdata_s),
        .out_valid(ov_s), .out_ready(ordy_s), .out_pixel(opix_s),
        .out_sof(sof_s), .out_eol(eol_s), .out_eof(eof_s),
        .busy(busy_s), .frame_done(fdone_s), .dropped(dropped_s)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // framebuffer memories: data returns one cycle after the read strobe
    always @(posedge clk) if (rd_en)   pdata   <= fb[addr];
    always @(posedge clk) if (rd_en_s) pdata_s <= fb_s[addr_s];

    task automatic chk(input bit ok, input string nm, input int act, input int req);
        n_cmp++;
        if (!ok) begin
            n_err++;
            $display("FAIL %s: got %0d, required %0d (t=%0t)", nm, act, req, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic beat_t mk(int x, int y, int w, int h, logic [1:0] p);
        return {p, (x == 0) && (y == 0), x == w - 1, (x == w - 1) && (y == h - 1)};
    endfunction

    task automatic fill_xy();
        for (int y = 0; y < H; y++)
            for (int x = 0; x < W; x++)
                fb[y * W + x] = 2'((x + y) % 4);
    endtask

    task automatic push_frame();
        for (int y = 0; y < H; y++)
            for (int x = 0; x < W; x++)
                exp_q.push_back(mk(x, y, W, H, fb[y * W + x]));
    endtask

    task automatic drop_pulse();
        rc = 1'b1;
        exp_drop = (exp_drop == 255) ? 255 : exp_drop + 1;
        tick();
        rc = 1'b0;
    endtask

    task automatic wait_beats(input int target, input string nm);
        int g = 0;
        while (beats < target && g < 60000) begin
            tick();
            g++;
        end
        if (beats < target) chk(1'b0, nm, beats, target);
    endtask

    task automatic mon_big();
        bit    pstall = 1'b0;
        bit    peof = 1'b0;
        beat_t pbeat = '0;
        beat_t act;
        beat_t e;
        forever begin
            @(negedge clk);
            act = {opix, sof, eol, eof};
            if (reset) begin
                exp_q.delete();
                pstall = 1'b0;
                peof = 1'b0;
            end else begin
                if (pstall) chk(ov && act == pbeat, "stall_hold", int'(act), int'(pbeat));
                if (fdone || peof) chk(fdone == peof, "frame_done_timing", int'(fdone), int'(peof));
                if (fdone) fd_n++;
                if (rd_en) chk(int'(addr) < N, "rd_addr_range", int'(addr), N - 1);
                if (ov && ordy) begin
                    if (exp_q.size() == 0) begin
                        chk(1'b0, "unexpected_beat", int'(act), 0);
                    end else begin
                        e = exp_q.pop_front();
                        chk(act == e, "beat", int'(act), int'(e));
                    end
                    beats++;
                    sof_n += int'(sof);
                    eol_n += int'(eol);
                    eof_n += int'(eof);
                    if (eof) frames_mon++;
                end
                pstall = ov && !ordy;
                pbeat = act;
                peof = ov && ordy && eof;
            end
        end
    endtask

    task automatic mon_small();
        bit    pstall = 1'b0;
        beat_t pbeat = '0;
        beat_t act;
        beat_t e;
        forever begin
            @(negedge clk);
            act = {opix_s, sof_s, eol_s, eof_s};
            if (reset) begin
                exp_qs.delete();
                pstall = 1'b0;
            end else begin
                if (pstall) chk(ov_s && act == pbeat, "small_stall_hold", int'(act), int'(pbeat));
                if (ov_s && ordy_s) begin
                    if (exp_qs.size() == 0) begin
                        chk(1'b0, "small_unexpected_beat", int'(act), 0);
                    end else begin
                        e = exp_qs.pop_front();
                        chk(act == e, "small_beat", int'(act), int'(e));
                    end
                    beats_s++;
                    if (eof_s) frames_s++;
                end
                pstall = ov_s && !ordy_s;
                pbeat = act;
            end
        end
    endtask

    initial begin
        int b0;
        int f0;
        int g;
        int sent;
        int rdn;

        reset = 1'b1; rc = 1'b0; ordy = 1'b1; rc_s = 1'b0; ordy_s = 1'b0;
        fork
            mon_big();
            mon_small();
        join_none

        // reset state
        #12;
        chk(ov == 0 && busy == 0 && rd_en == 0 && fdone == 0, "reset_ctrl", int'({ov, busy, rd_en, fdone}), 0);
        chk(addr == 0 && dropped == 0, "reset_addr_drop", int'(addr) + int'(dropped), 0);
        @(negedge clk);
        reset = 1'b0;
        tick();

        // frame A: (x+y)%4, always ready, latency and dropped-pulse checks
        fill_xy();
        b0 = beats;
        push_frame();
        rc = 1'b1;
        tick();
        rc = 1'b0;
        chk(rd_en == 1, "rd_latency", int'(rd_en), 1);
        chk(addr == 0, "first_addr", int'(addr), 0);
        chk(ov == 0, "valid_not_early", int'(ov), 0);
        tick();
        chk(ov == 1, "valid_latency", int'(ov), 1);
        wait_beats(b0 + 100, "timeout_A100");
        drop_pulse();
        wait_beats(b0 + 10000, "timeout_A10000");
        drop_pulse();
        g = 0;
        while (!(ov && ordy && eof) && g < 30000) begin
            tick();
            g++;
        end
        chk(ov && eof, "eof_reached", int'(eof), 1);
        drop_pulse();   // lands on the eof transfer edge
        repeat (5) tick();
        chk(beats - b0 == N, "frameA_beats", beats - b0, N);
        chk(fd_n == 1, "frame_done_count", fd_n, 1);
        chk(sof_n == 1, "sof_count", sof_n, 1);
        chk(eol_n == H, "eol_count", eol_n, H);
        chk(eof_n == 1, "eof_count", eof_n, 1);
        chk(int'(dropped) == exp_drop, "dropped_3", int'(dropped), exp_drop);
        chk(busy == 0 && ov == 0, "no_restart_after_eof_pulse", int'({busy, ov}), 0);
        chk(exp_q.size() == 0, "frameA_queue_empty", exp_q.size(), 0);

        // frame B: random image, random ready, 300 pulses while busy
        for (int i = 0; i < N; i++) fb[i] = 2'($urandom());
        b0 = beats;
        f0 = frames_mon;
        push_frame();
        rc = 1'b1;
        tick();
        rc = 1'b0;
        sent = 0;
        g = 0;
        while (frames_mon == f0 && g < 60000) begin
            ordy = 1'($urandom_range(0, 1));
            rc = (sent < 300) && (g % 3 == 2);
            if (rc) begin
                sent++;
                exp_drop = (exp_drop == 255) ? 255 : exp_drop + 1;
            end
            tick();
            g++;
        end
        rc = 1'b0;
        ordy = 1'b1;
        chk(frames_mon != f0, "frameB_done", frames_mon - f0, 1);
        tick();
        chk(beats - b0 == N, "frameB_beats", beats - b0, N);
        chk(int'(dropped) == exp_drop, "dropped_saturate", int'(dropped), exp_drop);
        chk(exp_q.size() == 0, "frameB_queue_empty", exp_q.size(), 0);

        // frame C: reset at beat 5000, then restart
        fill_xy();
        b0 = beats;
        push_frame();
        rc = 1'b1;
        tick();
        rc = 1'b0;
        wait_beats(b0 + 5000, "timeout_C5000");
        #2;
        reset = 1'b1;
        #1;
        chk(ov == 0 && busy == 0 && rd_en == 0 && fdone == 0, "async_reset_ctrl", int'({ov, busy, rd_en, fdone}), 0);
        chk({sof, eol, eof} == 3'b000 && opix == 2'd0, "async_reset_markers", int'({opix, sof, eol, eof}), 0);
        chk(addr == 0 && dropped == 0, "async_reset_addr_drop", int'(addr) + int'(dropped), 0);
        repeat (2) @(negedge clk);
        reset = 1'b0;
        exp_drop = 0;
        tick();
        b0 = beats;
        push_frame();
        rc = 1'b1;
        tick();
        rc = 1'b0;
        chk(rd_en == 1 && addr == 0, "restart_addr", int'(addr), 0);
        wait_beats(b0 + 300, "timeout_C300");
        chk(beats - b0 >= 300, "restart_beats", beats - b0, 300);
        #2;
        reset = 1'b1;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        tick();

        // small instance: stalled sink limits reads to FIFO depth, then drains
        for (int i = 0; i < NS; i++) fb_s[i] = 2'($urandom());
        for (int y = 0; y < HS; y++)
            for (int x = 0; x < WS; x++)
                exp_qs.push_back(mk(x, y, WS, HS, fb_s[y * WS + x]));
        ordy_s = 1'b0;
        rc_s = 1'b1;
        tick();
        rc_s = 1'b0;
        rdn = 0;
        for (int i = 0; i < 10; i++) begin
            rdn += int'(rd_en_s);
            tick();
        end
        chk(rdn == 2, "small_reads_when_stalled", rdn, 2);
        chk(ov_s && sof_s && opix_s == fb_s[0], "small_hold_beat0", int'({ov_s, sof_s, opix_s}), int'({2'b11, fb_s[0]}));
        ordy_s = 1'b1;
        g = 0;
        while (frames_s == 0 && g < 50) begin
            tick();
            g++;
        end
        tick();
        chk(beats_s == NS, "small_beats", beats_s, NS);
        chk(exp_qs.size() == 0, "small_queue_empty", exp_qs.size(), 0);
        chk(busy_s == 0 && dropped_s == 0, "small_idle", int'(busy_s) + int'(dropped_s), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
